// File: rtl/md5_pkg.sv
// Shared MD5 definitions: padder FSM states, padding constants, and the
// round-constant and shift tables used by the compute core.
package md5_pkg;

  typedef enum logic [2:0] {ST_MSG, ST_PAD, ST_ZERO, ST_LEN0, ST_LEN1} pad_state_e;

  localparam logic [7:0] PAD_BYTE  = 8'h80;
  localparam logic [5:0] LEN_POS   = 6'd56;
  localparam int         BLK_WORDS = 16;

  // K[i] = floor(|sin(i+1)| * 2^32)
  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Shift amounts repeat every 4 steps within a round.
  localparam logic [4:0] S_TAB [4][4] = '{
    '{5'd7, 5'd12, 5'd17, 5'd22},
    '{5'd5, 5'd9,  5'd14, 5'd20},
    '{5'd4, 5'd11, 5'd16, 5'd23},
    '{5'd6, 5'd10, 5'd15, 5'd21}
  };

  function automatic logic [4:0] s_of(input logic [5:0] step);
    return S_TAB[step[5:4]][step[1:0]];
  endfunction

endpackage

// File: rtl/md5_msg_padder_if.sv
// Byte-stream input and message-word output bundle of the MD5 padder.
interface md5_msg_padder_if;
  logic [7:0]  s_data_i;
  logic        s_valid_i;
  logic        s_last_i;
  logic        s_empty_i;
  logic        s_ready_o;
  logic [31:0] m_word_o;
  logic [3:0]  m_idx_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic        m_blk_end_o;
  logic        m_msg_end_o;

  modport slave (
    input  s_data_i, s_valid_i, s_last_i, s_empty_i, m_ready_i,
    output s_ready_o, m_word_o, m_idx_o, m_valid_o, m_blk_end_o, m_msg_end_o
  );

  modport master (
    output s_data_i, s_valid_i, s_last_i, s_empty_i, m_ready_i,
    input  s_ready_o, m_word_o, m_idx_o, m_valid_o, m_blk_end_o, m_msg_end_o
  );
endinterface

// File: rtl/md5_byte_packer.sv
// Little-endian lane accumulator feeding a single output word register with
// valid/ready handshake; can_complete tells the FSM a word may be loaded.
module md5_byte_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_we,
  input  logic [7:0]  byte_val,
  input  logic [5:0]  pos,
  input  logic        word_we,
  input  logic [31:0] word_val,
  input  logic [3:0]  word_idx,
  input  logic        msg_end,
  input  logic        m_ready,
  output logic        can_complete,
  output logic [31:0] m_word,
  output logic [3:0]  m_idx,
  output logic        m_valid,
  output logic        m_blk_end,
  output logic        m_msg_end
);
  logic [23:0] acc;
  logic        ld;
  logic [31:0] ld_word;
  logic [3:0]  ld_idx;

  assign can_complete = !m_valid || m_ready;
  assign ld      = word_we || (byte_we && pos[1:0] == 2'd3);
  assign ld_word = word_we ? word_val : {byte_val, acc};
  assign ld_idx  = word_we ? word_idx : pos[5:2];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc       <= '0;
      m_word    <= '0;
      m_idx     <= '0;
      m_valid   <= 1'b0;
      m_blk_end <= 1'b0;
      m_msg_end <= 1'b0;
    end else begin
      if (byte_we) begin
        case (pos[1:0])
          2'd0:    acc[7:0]   <= byte_val;
          2'd1:    acc[15:8]  <= byte_val;
          2'd2:    acc[23:16] <= byte_val;
          default: ;
        endcase
      end
      // Load wins over drain so a word can enter the cycle the previous one leaves.
      if (ld) begin
        m_valid   <= 1'b1;
        m_word    <= ld_word;
        m_idx     <= ld_idx;
        m_blk_end <= (ld_idx == 4'd15);
        m_msg_end <= word_we && msg_end;
      end else if (m_ready) begin
        m_valid   <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/md5_msg_padder.sv
// RFC 1321 message padder: bytes in, 16-word padded blocks out, one word per cycle.
module md5_msg_padder
  import md5_pkg::*;
#(
  parameter int LEN_W = 61
) (
  input  logic               clk_i,
  input  logic               rst_i,
  md5_msg_padder_if.slave    bus
);
  pad_state_e        state, state_n;
  logic [5:0]        pos, pos_n;
  logic [LEN_W-1:0]  byte_cnt, byte_cnt_n;
  logic [63:0]       bit_len;

  logic        byte_we, word_we, msg_end, can_complete, step_ok, s_ready;
  logic [7:0]  byte_val;
  logic [31:0] word_val;
  logic [3:0]  word_idx;

  assign bit_len       = 64'(byte_cnt) << 3;
  assign step_ok       = (pos[1:0] != 2'd3) || can_complete;
  assign bus.s_ready_o = s_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_MSG;
      pos      <= '0;
      byte_cnt <= '0;
    end else begin
      state    <= state_n;
      pos      <= pos_n;
      byte_cnt <= byte_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    pos_n      = pos;
    byte_cnt_n = byte_cnt;
    byte_we    = 1'b0;
    byte_val   = '0;
    word_we    = 1'b0;
    word_val   = '0;
    word_idx   = '0;
    msg_end    = 1'b0;
    s_ready    = 1'b0;
    case (state)
      ST_MSG: begin
        s_ready = step_ok && !rst_i;
        if (bus.s_valid_i && s_ready) begin
          if (!(bus.s_last_i && bus.s_empty_i)) begin
            byte_we    = 1'b1;
            byte_val   = bus.s_data_i;
            pos_n      = pos + 6'd1;
            byte_cnt_n = byte_cnt + LEN_W'(1);
          end
          if (bus.s_last_i) state_n = ST_PAD;
        end
      end
      ST_PAD, ST_ZERO: begin
        if (step_ok) begin
          byte_we  = 1'b1;
          byte_val = (state == ST_PAD) ? PAD_BYTE : 8'h00;
          pos_n    = pos + 6'd1;
          state_n  = (pos + 6'd1 == LEN_POS) ? ST_LEN0 : ST_ZERO;
        end
      end
      ST_LEN0: begin
        if (can_complete) begin
          word_we  = 1'b1;
          word_val = bit_len[31:0];
          word_idx = 4'd14;
          state_n  = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (can_complete) begin
          word_we    = 1'b1;
          word_val   = bit_len[63:32];
          word_idx   = 4'd15;
          msg_end    = 1'b1;
          state_n    = ST_MSG;
          pos_n      = '0;
          byte_cnt_n = '0;
        end
      end
      default: state_n = ST_MSG;
    endcase
  end

  md5_byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .byte_we      (byte_we),
    .byte_val     (byte_val),
    .pos          (pos),
    .word_we      (word_we),
    .word_val     (word_val),
    .word_idx     (word_idx),
    .msg_end      (msg_end),
    .m_ready      (bus.m_ready_i),
    .can_complete (can_complete),
    .m_word       (bus.m_word_o),
    .m_idx        (bus.m_idx_o),
    .m_valid      (bus.m_valid_o),
    .m_blk_end    (bus.m_blk_end_o),
    .m_msg_end    (bus.m_msg_end_o)
  );
endmodule
